// File: rtl/morse_char_tx_if.sv
// Character handshake and Morse output bundle between a message sequencer and morse_char_tx.
interface morse_char_tx_if #(
  parameter int MAX_SYM = 6,
  parameter int LEN_W   = 3
);
  logic               Start_Sig;
  logic [LEN_W-1:0]   Sym_Len;
  logic [MAX_SYM-1:0] Sym_Pat;
  logic               Word_End;
  logic               Busy;
  logic               Done_Sig;
  logic               Pin_Out;

  modport master (
    output Start_Sig, Sym_Len, Sym_Pat, Word_End,
    input  Busy, Done_Sig, Pin_Out
  );

  modport slave (
    input  Start_Sig, Sym_Len, Sym_Pat, Word_End,
    output Busy, Done_Sig, Pin_Out
  );
endinterface

// File: rtl/morse_char_tx.sv
// Morse character transmitter: one dot/dash pattern per handshake, timed in UNIT_CYCLES clocks.
// Optional MORSE_TONE_EN: marks become a TONE_HALF square wave for a passive buzzer.
module morse_char_tx #(
  parameter int UNIT_CYCLES = 4,
  parameter int MAX_SYM     = 6,
  parameter int LEN_W       = 3,
  parameter int TONE_HALF   = 2
) (
  input logic            CLK,
  input logic            RSTn,
  morse_char_tx_if.slave bus
);

  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  if (UNIT_CYCLES < 1 || TONE_HALF < 1 || (1 << LEN_W) <= MAX_SYM) begin : g_bad_params
    $error("morse_char_tx: invalid parameter set");
  end

  typedef enum logic [2:0] {IDLE, MARK, SPACE, GAP, DONE} state_t;

  state_t             state;
  logic [UW-1:0]      unit_cnt;
  logic [2:0]         mult_cnt;
  logic [2:0]         mult_last;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   sym_idx;
  logic [MAX_SYM-1:0] pat_q;
  logic               word_q;
  logic               pin_q;
  logic               busy_q;
  logic               done_q;
  logic [LEN_W-1:0]   len_clamped;
  logic               unit_end;
  logic               phase_end;

`ifdef MORSE_TONE_EN
  localparam int TW = $clog2(2 * TONE_HALF);
  logic [TW-1:0] tone_cnt;
`endif

  assign len_clamped = (bus.Sym_Len > LEN_W'(MAX_SYM)) ? LEN_W'(MAX_SYM) : bus.Sym_Len;
  assign unit_end    = (unit_cnt == UW'(UNIT_CYCLES - 1));
  assign phase_end   = unit_end && (mult_cnt == mult_last);

  // Phase length in units minus one; pat_q[0] is always the symbol being sent.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mult_last = 3'd0;
    case (state)
      MARK:    mult_last = pat_q[0] ? 3'd2 : 3'd0;
      GAP:     mult_last = word_q ? 3'd6 : 3'd2;
      default: mult_last = 3'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the async reset
  // also aborts a character in flight without emitting a Done pulse.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= IDLE;
      unit_cnt <= '0;
      mult_cnt <= '0;
      len_q    <= '0;
      sym_idx  <= '0;
      pat_q    <= '0;
      word_q   <= 1'b0;
      pin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MORSE_TONE_EN
      tone_cnt <= '0;
`endif
    end else begin
      if (state == MARK || state == SPACE || state == GAP) begin
        if (unit_end) begin
          unit_cnt <= '0;
          mult_cnt <= phase_end ? 3'd0 : mult_cnt + 3'd1;
        end else begin
          unit_cnt <= unit_cnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          pin_q  <= 1'b0;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.Start_Sig) begin
            len_q   <= len_clamped;
            pat_q   <= bus.Sym_Pat;
            word_q  <= bus.Word_End;
            sym_idx <= '0;
            busy_q  <= 1'b1;
            if (len_clamped != '0) begin
              state <= MARK;
              pin_q <= 1'b1;
`ifdef MORSE_TONE_EN
              tone_cnt <= TW'(1);
`endif
            end else begin
              state <= GAP;
            end
          end
        end

        MARK: begin
          if (phase_end) begin
            pin_q <= 1'b0;
            state <= (sym_idx + LEN_W'(1) == len_q) ? GAP : SPACE;
          end else begin
`ifdef MORSE_TONE_EN
            pin_q    <= (tone_cnt < TW'(TONE_HALF));
            tone_cnt <= (tone_cnt == TW'(2 * TONE_HALF - 1)) ? '0 : tone_cnt + 1'b1;
`else
            pin_q    <= 1'b1;
`endif
          end
        end

        SPACE: begin
          pin_q <= 1'b0;
          if (phase_end) begin
            sym_idx <= sym_idx + LEN_W'(1);
            pat_q   <= pat_q >> 1;
            pin_q   <= 1'b1;
            state   <= MARK;
`ifdef MORSE_TONE_EN
            tone_cnt <= TW'(1);
`endif
          end
        end

        GAP: begin
          pin_q <= 1'b0;
          if (phase_end) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Pin_Out  = pin_q;
  assign bus.Busy     = busy_q;
  assign bus.Done_Sig = done_q;

endmodule

// File: tb/tb_morse_char_tx.sv
// Directed self-checking bench for morse_char_tx (UNIT_CYCLES=4 main instance, UNIT_CYCLES=1 second instance).
module tb_morse_char_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  morse_char_tx_if #(.MAX_SYM(6), .LEN_W(3)) bus ();
  morse_char_tx_if #(.MAX_SYM(6), .LEN_W(3)) bus1 ();

  morse_char_tx #(.UNIT_CYCLES(4), .MAX_SYM(6), .LEN_W(3), .TONE_HALF(2)) dut (
    .CLK(clk), .RSTn(rst_n), .bus(bus)
  );

  morse_char_tx #(.UNIT_CYCLES(1), .MAX_SYM(6), .LEN_W(3), .TONE_HALF(2)) dut1 (
    .CLK(clk), .RSTn(rst_n), .bus(bus1)
  );

  int total = 0;
  int bad   = 0;

  logic [255:0] exp_pin, exp_done, exp_busy;
  logic [255:0] got_pin, got_done, got_busy;
  int           exp_len;
  logic         idle_busy, idle_done;

  task automatic clear_exp();
    exp_pin = '0;
    exp_len = 0;
  endtask

  task automatic add_seg(input logic level, input int n);
    for (int i = 0; i < n; i++) begin
      exp_pin[exp_len] = level;
      exp_len++;
    end
  endtask

  // Called at a negedge: the next posedge accepts. Logs cycles 1..exp_len+1
  // (the last being the expected Done cycle), then samples one idle cycle.
  task automatic run_char(input logic [2:0] len, input logic [5:0] pat,
                          input logic we, input bit toggle);
    int n;
    n = exp_len + 1;
    bus.Sym_Len   = len;
    bus.Sym_Pat   = pat;
    bus.Word_End  = we;
    bus.Start_Sig = 1'b1;
    got_pin = '0; got_done = '0; got_busy = '0;
    exp_done = '0; exp_busy = '0;
    exp_done[exp_len] = 1'b1;
    for (int i = 0; i < n; i++) exp_busy[i] = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (toggle && i < n - 1) begin
        bus.Start_Sig = i[0];
        bus.Sym_Pat   = ~bus.Sym_Pat;
        bus.Sym_Len   = bus.Sym_Len + 3'd1;
        bus.Word_End  = ~bus.Word_End;
      end else begin
        bus.Start_Sig = 1'b0;
      end
      got_pin[i]  = bus.Pin_Out;
      got_done[i] = bus.Done_Sig;
      got_busy[i] = bus.Busy;
    end
    @(negedge clk);
    idle_busy = bus.Busy;
    idle_done = bus.Done_Sig;
  endtask

  task automatic test_reset();
    bus.Start_Sig = 1'b1; bus.Sym_Len = 3'd1; bus.Sym_Pat = 6'd0; bus.Word_End = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.Pin_Out !== 1'b0)  begin bad++; $display("FAIL reset_pin got=%b want=0", bus.Pin_Out); end
    total++; if (bus.Busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", bus.Busy); end
    total++; if (bus.Done_Sig !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.Done_Sig); end
    rst_n = 1'b1;
    clear_exp(); add_seg(1'b1, 4); add_seg(1'b0, 12);
    run_char(3'd1, 6'd0, 1'b0, 1'b0);
    total++; if (got_pin !== exp_pin)   begin bad++; $display("FAIL reset_first_pin got=%h want=%h", got_pin, exp_pin); end
    total++; if (got_done !== exp_done) begin bad++; $display("FAIL reset_first_done got=%h want=%h", got_done, exp_done); end
  endtask

  task automatic test_s();
    clear_exp();
    add_seg(1'b1, 4); add_seg(1'b0, 4); add_seg(1'b1, 4); add_seg(1'b0, 4);
    add_seg(1'b1, 4); add_seg(1'b0, 12);
    run_char(3'd3, 6'b000000, 1'b0, 1'b0);
    total++; if (got_pin !== exp_pin)   begin bad++; $display("FAIL s_pin got=%h want=%h", got_pin, exp_pin); end
    total++; if (got_done !== exp_done) begin bad++; $display("FAIL s_done got=%h want=%h", got_done, exp_done); end
    total++; if (got_busy !== exp_busy) begin bad++; $display("FAIL s_busy got=%h want=%h", got_busy, exp_busy); end
    total++; if ({idle_busy, idle_done} !== 2'b00) begin bad++; $display("FAIL s_idle got=%b want=00", {idle_busy, idle_done}); end
  endtask

  task automatic test_sos();
    int dones;
    dones = 0;
    clear_exp();
    add_seg(1'b1, 4); add_seg(1'b0, 4); add_seg(1'b1, 4); add_seg(1'b0, 4);
    add_seg(1'b1, 4); add_seg(1'b0, 12);
    run_char(3'd3, 6'b000000, 1'b0, 1'b0);
    dones += $countones(got_done) + int'(idle_done);
    clear_exp();
    add_seg(1'b1, 12); add_seg(1'b0, 4); add_seg(1'b1, 12); add_seg(1'b0, 4);
    add_seg(1'b1, 12); add_seg(1'b0, 12);
    run_char(3'd3, 6'b000111, 1'b0, 1'b0);
    dones += $countones(got_done) + int'(idle_done);
    total++; if (got_pin !== exp_pin) begin bad++; $display("FAIL sos_o_pin got=%h want=%h", got_pin, exp_pin); end
    clear_exp();
    add_seg(1'b1, 4); add_seg(1'b0, 4); add_seg(1'b1, 4); add_seg(1'b0, 4);
    add_seg(1'b1, 4); add_seg(1'b0, 28);
    run_char(3'd3, 6'b000000, 1'b1, 1'b0);
    dones += $countones(got_done) + int'(idle_done);
    total++; if (got_pin !== exp_pin)   begin bad++; $display("FAIL sos_s_word_pin got=%h want=%h", got_pin, exp_pin); end
    total++; if (got_done !== exp_done) begin bad++; $display("FAIL sos_s_word_done got=%h want=%h", got_done, exp_done); end
    total++; if (dones != 3) begin bad++; $display("FAIL sos_done_count got=%0d want=3", dones); end
  endtask

  task automatic test_len0();
    clear_exp(); add_seg(1'b0, 28);
    run_char(3'd0, 6'b111111, 1'b1, 1'b0);
    total++; if (got_pin !== exp_pin)   begin bad++; $display("FAIL len0_pin got=%h want=%h", got_pin, exp_pin); end
    total++; if (got_done !== exp_done) begin bad++; $display("FAIL len0_done got=%h want=%h", got_done, exp_done); end
    total++; if (got_busy !== exp_busy) begin bad++; $display("FAIL len0_busy got=%h want=%h", got_busy, exp_busy); end
  endtask

  task automatic test_clamp();
    int marks;
    marks = 0;
    clear_exp();
    for (int k = 0; k < 6; k++) begin
      add_seg(1'b1, 4);
      if (k < 5) add_seg(1'b0, 4);
    end
    add_seg(1'b0, 12);
    run_char(3'd7, 6'b000000, 1'b0, 1'b0);
    for (int i = 1; i < 256; i++) if (got_pin[i] && !got_pin[i-1]) marks++;
    if (got_pin[0]) marks++;
    total++; if (got_pin !== exp_pin)   begin bad++; $display("FAIL clamp_pin got=%h want=%h", got_pin, exp_pin); end
    total++; if (got_done !== exp_done) begin bad++; $display("FAIL clamp_done got=%h want=%h", got_done, exp_done); end
    total++; if (marks != 6) begin bad++; $display("FAIL clamp_marks got=%0d want=6", marks); end
  endtask

  task automatic test_bit_order();
    clear_exp();
    add_seg(1'b1, 12); add_seg(1'b0, 4); add_seg(1'b1, 4); add_seg(1'b0, 12);
    run_char(3'd2, 6'b000001, 1'b0, 1'b0);
    total++; if (got_pin !== exp_pin)   begin bad++; $display("FAIL order_pin got=%h want=%h", got_pin, exp_pin); end
    total++; if (got_done !== exp_done) begin bad++; $display("FAIL order_done got=%h want=%h", got_done, exp_done); end
  endtask

  task automatic test_busy_ignore();
    clear_exp();
    add_seg(1'b1, 4); add_seg(1'b0, 4); add_seg(1'b1, 12); add_seg(1'b0, 12);
    run_char(3'd2, 6'b000010, 1'b0, 1'b1);
    total++; if (got_pin !== exp_pin)   begin bad++; $display("FAIL ignore_pin got=%h want=%h", got_pin, exp_pin); end
    total++; if (got_done !== exp_done) begin bad++; $display("FAIL ignore_done got=%h want=%h", got_done, exp_done); end
    total++; if ({idle_busy, idle_done} !== 2'b00) begin bad++; $display("FAIL ignore_idle got=%b want=00", {idle_busy, idle_done}); end
  endtask

  task automatic test_back_to_back();
    clear_exp();
    add_seg(1'b1, 4); add_seg(1'b0, 12); add_seg(1'b0, 1); add_seg(1'b0, 1);
    add_seg(1'b1, 4); add_seg(1'b0, 12); add_seg(1'b0, 1);
    exp_done = '0; exp_done[16] = 1'b1; exp_done[34] = 1'b1;
    exp_busy = '0;
    for (int i = 0; i < 35; i++) if (i != 17) exp_busy[i] = 1'b1;
    got_pin = '0; got_done = '0; got_busy = '0;
    bus.Sym_Len = 3'd1; bus.Sym_Pat = 6'd0; bus.Word_End = 1'b0; bus.Start_Sig = 1'b1;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (i == 34) bus.Start_Sig = 1'b0;
      got_pin[i]  = bus.Pin_Out;
      got_done[i] = bus.Done_Sig;
      got_busy[i] = bus.Busy;
    end
    total++; if (got_pin !== exp_pin)   begin bad++; $display("FAIL b2b_pin got=%h want=%h", got_pin, exp_pin); end
    total++; if (got_done !== exp_done) begin bad++; $display("FAIL b2b_done got=%h want=%h", got_done, exp_done); end
    total++; if (got_busy !== exp_busy) begin bad++; $display("FAIL b2b_busy got=%h want=%h", got_busy, exp_busy); end
  endtask

  task automatic test_mid_reset();
    logic seen_done;
    seen_done = 1'b0;
    bus.Sym_Len = 3'd3; bus.Sym_Pat = 6'd0; bus.Word_End = 1'b0; bus.Start_Sig = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.Start_Sig = 1'b0;
    end
    total++; if (bus.Pin_Out !== 1'b1) begin bad++; $display("FAIL midrst_mark2 got=%b want=1", bus.Pin_Out); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.Pin_Out !== 1'b0) begin bad++; $display("FAIL midrst_pin got=%b want=0", bus.Pin_Out); end
    total++; if (bus.Busy !== 1'b0)    begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.Busy); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.Done_Sig) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.Done_Sig) seen_done = 1'b1;
    end
    total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL midrst_no_done got=%b want=0", seen_done); end
    clear_exp(); add_seg(1'b1, 4); add_seg(1'b0, 12);
    run_char(3'd1, 6'd0, 1'b0, 1'b0);
    total++; if (got_pin !== exp_pin)   begin bad++; $display("FAIL midrst_e_pin got=%h want=%h", got_pin, exp_pin); end
    total++; if (got_done !== exp_done) begin bad++; $display("FAIL midrst_e_done got=%h want=%h", got_done, exp_done); end
  endtask

  task automatic test_unit1();
    logic [15:0] p, d;
    p = '0; d = '0;
    bus1.Sym_Len = 3'd2; bus1.Sym_Pat = 6'b000010; bus1.Word_End = 1'b0; bus1.Start_Sig = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus1.Start_Sig = 1'b0;
      p[i] = bus1.Pin_Out;
      d[i] = bus1.Done_Sig;
    end
    total++; if (p !== 16'h001D) begin bad++; $display("FAIL unit1_pin got=%h want=001d", p); end
    total++; if (d !== 16'h0100) begin bad++; $display("FAIL unit1_done got=%h want=0100", d); end
  endtask

  task automatic test_dash_tone();
    clear_exp();
`ifdef MORSE_TONE_EN
    for (int k = 0; k < 3; k++) begin
      add_seg(1'b1, 2); add_seg(1'b0, 2);
    end
`else
    add_seg(1'b1, 12);
`endif
    add_seg(1'b0, 12);
    run_char(3'd1, 6'b000001, 1'b0, 1'b0);
    total++; if (got_pin !== exp_pin)   begin bad++; $display("FAIL dash_pin got=%h want=%h", got_pin, exp_pin); end
    total++; if (got_done !== exp_done) begin bad++; $display("FAIL dash_done got=%h want=%h", got_done, exp_done); end
  endtask

  initial begin
    bus1.Start_Sig = 1'b0; bus1.Sym_Len = '0; bus1.Sym_Pat = '0; bus1.Word_End = 1'b0;
    @(negedge clk);
    test_reset();
    test_s();
    test_sos();
    test_len0();
    test_clamp();
    test_bit_order();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_unit1();
    test_dash_tone();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
